wb_arbiter_rr: RTL and testbench
================================

# wb_arbiter_rr

Parametrised round-robin Wishbone B3 arbiter that lets NUM_MASTERS bus masters share one slave port, such as a shared memory behind the CPU instruction and data muxes. Ownership is burst-aware: a master keeps the grant until it drops cyc. Arbitration is fair, rotating among requesters. An optional watchdog terminates transfers the slave never answers with an error to the owning master.

## Interface
- NUM_MASTERS, 2: number of masters; legal values are 2 to 16.
- AW, 32: address width.
- DW, 32: data width; sel width is DW/8.
- TIMEOUT_CYCLES, 1024: watchdog limit in cycles; legal values are 2 to 65535.
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbm_adr_i, wbm_dat_i, wbm_sel_i  in  NUM_MASTERS*AW, NUM_MASTERS*DW, NUM_MASTERS*DW/8  packed master request fields; master 0 occupies the LSBs.
- wbm_we_i, wbm_cyc_i, wbm_stb_i  in  NUM_MASTERS each  per-master control.
- wbm_cti_i, wbm_bte_i  in  NUM_MASTERS*3, NUM_MASTERS*2  burst type fields.
- wbm_dat_o  out  NUM_MASTERS*DW  read data; wbs_dat_i is broadcast to all masters.
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  NUM_MASTERS each  responses; only the owner can see a 1.
- wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out  AW, DW, DW/8, 1, 1, 1, 3, 2  slave request.
- wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i  in  DW, 1, 1, 1  slave response.
- owner_o  out  $clog2(NUM_MASTERS)  index of the current owner; valid only while wbs_cyc_o is high.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

## Operation
- State is held in a grant_vld flag, an owner index and a last index. The arbiter is IDLE when grant_vld=0 and GRANTED when grant_vld=1.
- IDLE: if any wbm_cyc_i bit is high, the arbiter registers a winner and moves to GRANTED. The winner is the first requester scanning upward from last+1 modulo NUM_MASTERS.
- GRANTED:
  - wbs_* request fields are a combinational mux of the owner's fields.
  - wbs_cyc_o = wbm_cyc_i[owner].
  - wbs_stb_o = wbm_stb_i[owner].
  - Slave ack, err and rty are routed to the owner only.
- Release: on an edge where wbm_cyc_i[owner] is low, last <= owner and the arbiter re-scans requesters in that same edge.
  - If another master is requesting, it is granted with no idle cycle.
  - Otherwise the arbiter returns to IDLE.
  - The departing master is scanned last, so it is re-granted only if it is the sole requester.
- The grant never moves while the owner holds cyc. This covers multi-beat bursts (cti 3'b010) and RMW sequences.
- Reset values:
  - grant_vld=0, owner=0, last=NUM_MASTERS-1, so master 0 has first priority after reset.
  - Watchdog counter=0.
  - All wbs_cyc_o, wbs_stb_o and wbm_ack/err/rty_o outputs are 0; timeout_o=0.
- Reset mid-transfer: grant_vld clears at that edge. wbs_cyc_o is low from the next cycle, and no response reaches any master.

## Timing
- Grant latency from IDLE: 1 cycle. When wbm_cyc_i rises at edge N, wbs_cyc_o is high after edge N+1.
- Back-to-back handover: 0 idle cycles.
- Response path is combinational: slave to master ack has 0 cycles of added latency.
- Watchdog counter:
  - Increments each cycle that wbs_stb_o=1 and ack, err and rty are all 0.
  - Clears on any response, when stb is low, or on an ownership change.
- Watchdog firing: when the counter equals TIMEOUT_CYCLES-1 with no response:
  - wbm_err_o[owner]=1 and timeout_o=1 for that cycle.
  - wbs_stb_o is forced 0 for that cycle.
  - The counter clears.
- A slave response in the same cycle as the limit wins: a normal response is passed through and no error is generated.

## Configuration
- WB_ARB_TIMEOUT_EN
  - Defined: the watchdog is present as described above.
  - Undefined: no counter is built, timeout_o is tied to 0, wbs_stb_o is never forced low, and a hung slave stalls the bus indefinitely.

## Structure
- Shared package wb_arb_pkg holds:
  - CTI constants: CLASSIC 3'b000, INC 3'b010, EOB 3'b111.
  - BTE_LINEAR.
  - DEFAULT_TIMEOUT=1024.
- Sub-module wb_arb_rr_pick: a combinational rotating priority encoder. Inputs are the req vector and a start index; outputs are a found flag and the winner index. It is reused for both the IDLE and release scans.

## Test plan
- Single master: NUM_MASTERS=4, only master 2 requests a read of address 0x100; slave acks after 3 cycles. Required: wbs_cyc_o rises 1 cycle after wbm_cyc_i[2], owner_o=2, wbm_ack_o=4'b0100 for exactly one cycle.
- Fairness: all 4 masters hold cyc continuously and each drops cyc after one acked beat. Required: grant order is 0,1,2,3,0 with no idle cycles between owners.
- Burst lock: master 1 runs a 4-beat INC burst while master 0 requests. Required: master 0 is granted only after master 1's EOB beat completes and master 1 drops cyc.
- Watchdog (TIMEOUT_CYCLES=8, macro defined): slave never responds. Required: after 8 cycles of stb the owner sees err=1 and timeout_o=1 for one cycle, and wbs_stb_o=0 in that cycle.
- Ack at limit: slave acks in exactly the 8th stalled cycle. Required: the owner receives ack, err stays 0 and timeout_o stays 0.
- Reset mid-burst: wb_rst_i is asserted during beat 2 of a burst. Required: wbs_cyc_o=0 on the next cycle, and after reset a request from master 0 wins over master 3.

Source files
------------

// File: rtl/wb_arbiter_rr_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    localparam int unsigned DEFAULT_TIMEOUT = 1024;

    // Next index after idx in a ring of n entries.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_if.sv
// Bundle of the arbiter's master-side and slave-side Wishbone signals.
interface wb_arbiter_rr_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32
);
    localparam int unsigned SW = DW / 8;

    logic [NUM_MASTERS*AW-1:0] wbm_adr_i;
    logic [NUM_MASTERS*DW-1:0] wbm_dat_i;
    logic [NUM_MASTERS*SW-1:0] wbm_sel_i;
    logic [NUM_MASTERS-1:0]    wbm_we_i;
    logic [NUM_MASTERS-1:0]    wbm_cyc_i;
    logic [NUM_MASTERS-1:0]    wbm_stb_i;
    logic [NUM_MASTERS*3-1:0]  wbm_cti_i;
    logic [NUM_MASTERS*2-1:0]  wbm_bte_i;
    logic [NUM_MASTERS*DW-1:0] wbm_dat_o;
    logic [NUM_MASTERS-1:0]    wbm_ack_o;
    logic [NUM_MASTERS-1:0]    wbm_err_o;
    logic [NUM_MASTERS-1:0]    wbm_rty_o;

    logic [AW-1:0] wbs_adr_o;
    logic [DW-1:0] wbs_dat_o;
    logic [SW-1:0] wbs_sel_o;
    logic          wbs_we_o;
    logic          wbs_cyc_o;
    logic          wbs_stb_o;
    logic [2:0]    wbs_cti_o;
    logic [1:0]    wbs_bte_o;
    logic [DW-1:0] wbs_dat_i;
    logic          wbs_ack_i;
    logic          wbs_err_i;
    logic          wbs_rty_i;

    // Arbiter view: consumes master requests and slave responses.
    modport arb (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbm_cti_i, wbm_bte_i, wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
               wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
               wbs_cti_o, wbs_bte_o
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbm_cti_i, wbm_bte_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o
    );

    modport slave (
        input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
               wbs_cti_o, wbs_bte_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
    );

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Rotating priority encoder: first set req bit scanning upward from start_i, wrapping.
module wb_arb_rr_pick #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);
    localparam int unsigned CWID = IW + 1;

    logic [CWID-1:0] cand;

    // Scan from lowest priority down so the highest-priority hit is assigned last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            cand = {1'b0, start_i} + CWID'(i);
            if (cand >= CWID'(N)) begin
                cand = cand - CWID'(N);
            end
            if (req_i[cand[IW-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Burst-aware round-robin Wishbone B3 arbiter, NUM_MASTERS masters onto one slave.
// Optional slave-hang watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter  int unsigned NUM_MASTERS    = 2,
    parameter  int unsigned AW             = 32,
    parameter  int unsigned DW             = 32,
    parameter  int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    localparam int unsigned IW             = $clog2(NUM_MASTERS)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    wb_arbiter_rr_if.arb  bus,
    output logic [IW-1:0] owner_o,
    output logic          timeout_o
);
    localparam int unsigned SW = DW / 8;
    localparam int unsigned CW = 16;

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        pick_start, pick_idx;
    logic                 pick_found;
    logic                 grant_vld;
    logic                 wd_fire;

    logic [AW-1:0]        own_adr;
    logic [DW-1:0]        own_dat;
    logic [SW-1:0]        own_sel;
    logic                 own_we, own_cyc, own_stb;
    logic [2:0]           own_cti;
    logic [1:0]           own_bte;
    logic [NUM_MASTERS-1:0] ack_v, err_v, rty_v;

    assign grant_vld = (state_q == ARB_GRANTED);

    wb_arb_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req_i   (bus.wbm_cyc_i),
        .start_i (pick_start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Select the current owner's request fields.
    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_we  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_cti = CTI_CLASSIC;
        own_bte = BTE_LINEAR;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (owner_q == IW'(i)) begin
                own_adr = bus.wbm_adr_i[i*AW +: AW];
                own_dat = bus.wbm_dat_i[i*DW +: DW];
                own_sel = bus.wbm_sel_i[i*SW +: SW];
                own_we  = bus.wbm_we_i[i];
                own_cyc = bus.wbm_cyc_i[i];
                own_stb = bus.wbm_stb_i[i];
                own_cti = bus.wbm_cti_i[i*3 +: 3];
                own_bte = bus.wbm_bte_i[i*2 +: 2];
            end
        end
    end

    // Grant FSM: the scan starts after last when idle, after the departing owner on release.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        pick_start = IW'(wrap_inc(32'(grant_vld ? owner_q : last_q), NUM_MASTERS));
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_GRANTED;
                    owner_d = pick_idx;
                end
            end
            ARB_GRANTED: begin
                if (!own_cyc) begin
                    last_d = owner_q;
                    if (pick_found) begin
                        owner_d = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;

    // A stall only counts while the owner holds cyc, so a handover always clears it.
    always_comb begin
        wd_fire  = 1'b0;
        wd_cnt_d = '0;
        if (grant_vld && own_cyc && own_stb &&
            !(bus.wbs_ack_i || bus.wbs_err_i || bus.wbs_rty_i)) begin
            if (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                wd_fire = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign wd_fire            = 1'b0;
`endif

    // Responses reach the owner only; a watchdog fire appears as an error.
    always_comb begin
        ack_v = '0;
        err_v = '0;
        rty_v = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (grant_vld && owner_q == IW'(i)) begin
                ack_v[i] = bus.wbs_ack_i;
                err_v[i] = bus.wbs_err_i | wd_fire;
                rty_v[i] = bus.wbs_rty_i;
            end
        end
    end

    assign bus.wbm_ack_o = ack_v;
    assign bus.wbm_err_o = err_v;
    assign bus.wbm_rty_o = rty_v;
    assign bus.wbm_dat_o = {NUM_MASTERS{bus.wbs_dat_i}};

    assign bus.wbs_adr_o = own_adr;
    assign bus.wbs_dat_o = own_dat;
    assign bus.wbs_sel_o = own_sel;
    assign bus.wbs_we_o  = own_we;
    assign bus.wbs_cti_o = own_cti;
    assign bus.wbs_bte_o = own_bte;
    assign bus.wbs_cyc_o = grant_vld & own_cyc;
    assign bus.wbs_stb_o = grant_vld & own_stb & ~wd_fire;

    assign owner_o   = owner_q;
    assign timeout_o = wd_fire;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed self-checking bench for wb_arbiter_rr with four masters and an 8-cycle watchdog.
module tb_wb_arbiter_rr;
    import wb_arb_pkg::*;

    localparam int unsigned NM = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] owner;
    logic       timeout;
    int         checks = 0;
    int         errors = 0;

    wb_arbiter_rr_if #(.NUM_MASTERS(NM), .AW(AW), .DW(DW)) bus ();

    wb_arbiter_rr #(
        .NUM_MASTERS    (NM),
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .bus       (bus),
        .owner_o   (owner),
        .timeout_o (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wbm_adr_i = '0;
        bus.wbm_dat_i = '0;
        bus.wbm_sel_i = '1;
        bus.wbm_we_i  = '0;
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        bus.wbm_cti_i = '0;
        bus.wbm_bte_i = '0;
        bus.wbs_dat_i = '0;
        bus.wbs_ack_i = 1'b0;
        bus.wbs_err_i = 1'b0;
        bus.wbs_rty_i = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reset must hold every output low even with requests and a slave ack present.
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.wbm_cyc_i = '1;
        bus.wbm_stb_i = '1;
        bus.wbs_ack_i = 1'b1;
        tick();
        tick();
        checks++; if (bus.wbs_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", bus.wbs_cyc_o); end
        checks++; if (bus.wbs_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", bus.wbs_stb_o); end
        checks++; if (bus.wbm_ack_o !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", bus.wbm_ack_o); end
        checks++; if (bus.wbm_err_o !== 4'b0000 || bus.wbm_rty_o !== 4'b0000) begin errors++; $display("FAIL reset_err_rty: got %b/%b want 0000/0000", bus.wbm_err_o, bus.wbm_rty_o); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_master();
        do_reset();
        bus.wbm_adr_i[2*AW +: AW] = 32'h0000_0100;
        bus.wbm_cyc_i[2] = 1'b1;
        bus.wbm_stb_i[2] = 1'b1;
        #1;
        checks++; if (bus.wbs_cyc_o !== 1'b0) begin errors++; $display("FAIL single_early_grant: got %b want 0", bus.wbs_cyc_o); end
        tick();
        #1;
        checks++; if (bus.wbs_cyc_o !== 1'b1 || owner !== 2'd2) begin errors++; $display("FAIL single_grant: cyc %b owner %0d want 1 2", bus.wbs_cyc_o, owner); end
        checks++; if (bus.wbs_adr_o !== 32'h0000_0100 || bus.wbs_we_o !== 1'b0) begin errors++; $display("FAIL single_adr: got %h we %b want 00000100 0", bus.wbs_adr_o, bus.wbs_we_o); end
        tick();
        tick();
        bus.wbs_ack_i = 1'b1;
        bus.wbs_dat_i = 32'hCAFE_F00D;
        #1;
        checks++; if (bus.wbm_ack_o !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b want 0100", bus.wbm_ack_o); end
        checks++; if (bus.wbm_dat_o[2*DW +: DW] !== 32'hCAFE_F00D) begin errors++; $display("FAIL single_rdata: got %h want cafef00d", bus.wbm_dat_o[2*DW +: DW]); end
        tick();
        bus.wbs_ack_i = 1'b0;
        bus.wbm_cyc_i[2] = 1'b0;
        bus.wbm_stb_i[2] = 1'b0;
        #1;
        checks++; if (bus.wbm_ack_o !== 4'b0000) begin errors++; $display("FAIL single_ack_once: got %b want 0000", bus.wbm_ack_o); end
        tick();
    endtask

    task automatic test_fairness();
        int unsigned order [5] = '{0, 1, 2, 3, 0};
        logic [3:0]  exp_v;
        do_reset();
        bus.wbm_cyc_i = 4'hF;
        bus.wbm_stb_i = 4'hF;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_v = 4'b0001 << order[k];
            bus.wbs_ack_i = 1'b1;
            #1;
            checks++; if (owner !== 2'(order[k]) || bus.wbs_cyc_o !== 1'b1) begin errors++; $display("FAIL fair_owner_%0d: owner %0d cyc %b want %0d 1", k, owner, bus.wbs_cyc_o, order[k]); end
            checks++; if (bus.wbm_ack_o !== exp_v) begin errors++; $display("FAIL fair_ack_%0d: got %b want %b", k, bus.wbm_ack_o, exp_v); end
            tick();
            bus.wbs_ack_i = 1'b0;
            bus.wbm_cyc_i[order[k]] = 1'b0;
            bus.wbm_stb_i[order[k]] = 1'b0;
            tick();
            bus.wbm_cyc_i[order[k]] = 1'b1;
            bus.wbm_stb_i[order[k]] = 1'b1;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_burst_lock();
        logic [2:0] cti;
        do_reset();
        bus.wbm_cti_i[1*3 +: 3] = CTI_INC;
        bus.wbm_cyc_i[1] = 1'b1;
        bus.wbm_stb_i[1] = 1'b1;
        tick();
        bus.wbm_cyc_i[0] = 1'b1;
        bus.wbm_stb_i[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            cti = (b == 3) ? CTI_EOB : CTI_INC;
            bus.wbm_cti_i[1*3 +: 3] = cti;
            bus.wbm_adr_i[1*AW +: AW] = 32'h200 + 32'(4 * b);
            bus.wbs_ack_i = 1'b1;
            #1;
            checks++; if (owner !== 2'd1 || bus.wbs_cti_o !== cti) begin errors++; $display("FAIL burst_beat_%0d: owner %0d cti %b want 1 %b", b, owner, bus.wbs_cti_o, cti); end
            checks++; if (bus.wbm_ack_o !== 4'b0010) begin errors++; $display("FAIL burst_ack_%0d: got %b want 0010", b, bus.wbm_ack_o); end
            tick();
        end
        bus.wbs_ack_i = 1'b0;
        bus.wbm_cyc_i[1] = 1'b0;
        bus.wbm_stb_i[1] = 1'b0;
        bus.wbm_cti_i[1*3 +: 3] = CTI_CLASSIC;
        #1;
        checks++; if (owner !== 2'd1 || bus.wbs_cyc_o !== 1'b0) begin errors++; $display("FAIL burst_release_cycle: owner %0d cyc %b want 1 0", owner, bus.wbs_cyc_o); end
        tick();
        #1;
        checks++; if (owner !== 2'd0 || bus.wbs_cyc_o !== 1'b1) begin errors++; $display("FAIL burst_handover: owner %0d cyc %b want 0 1", owner, bus.wbs_cyc_o); end
        clear_inputs();
        tick();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_watchdog();
        do_reset();
        bus.wbm_cyc_i[3] = 1'b1;
        bus.wbm_stb_i[3] = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (c < 8) begin
                checks++; if ({bus.wbm_err_o, timeout, bus.wbs_stb_o} !== 6'b0000_0_1) begin errors++; $display("FAIL wd_stall_%0d: err %b to %b stb %b want 0000 0 1", c, bus.wbm_err_o, timeout, bus.wbs_stb_o); end
            end else begin
                checks++; if (bus.wbm_err_o !== 4'b1000 || timeout !== 1'b1) begin errors++; $display("FAIL wd_fire: err %b to %b want 1000 1", bus.wbm_err_o, timeout); end
                checks++; if (bus.wbs_stb_o !== 1'b0) begin errors++; $display("FAIL wd_stb_forced: got %b want 0", bus.wbs_stb_o); end
            end
            tick();
        end
        #1;
        checks++; if ({bus.wbm_err_o, timeout, bus.wbs_stb_o} !== 6'b0000_0_1) begin errors++; $display("FAIL wd_cleared: err %b to %b stb %b want 0000 0 1", bus.wbm_err_o, timeout, bus.wbs_stb_o); end
        clear_inputs();
        tick();
    endtask

    task automatic test_ack_at_limit();
        do_reset();
        bus.wbm_cyc_i[2] = 1'b1;
        bus.wbm_stb_i[2] = 1'b1;
        tick();
        for (int c = 1; c < 8; c++) begin
            #1;
            checks++; if ({bus.wbm_err_o, timeout, bus.wbm_ack_o} !== 9'b0) begin errors++; $display("FAIL limit_stall_%0d: err %b to %b ack %b want zeros", c, bus.wbm_err_o, timeout, bus.wbm_ack_o); end
            tick();
        end
        bus.wbs_ack_i = 1'b1;
        #1;
        checks++; if (bus.wbm_ack_o !== 4'b0100) begin errors++; $display("FAIL limit_ack: got %b want 0100", bus.wbm_ack_o); end
        checks++; if (bus.wbm_err_o !== 4'b0000 || timeout !== 1'b0) begin errors++; $display("FAIL limit_no_err: err %b to %b want 0000 0", bus.wbm_err_o, timeout); end
        checks++; if (bus.wbs_stb_o !== 1'b1) begin errors++; $display("FAIL limit_stb: got %b want 1", bus.wbs_stb_o); end
        clear_inputs();
        tick();
    endtask
`else
    task automatic test_no_watchdog();
        do_reset();
        bus.wbm_cyc_i[3] = 1'b1;
        bus.wbm_stb_i[3] = 1'b1;
        tick();
        for (int c = 1; c <= 12; c++) begin
            #1;
            checks++; if ({bus.wbm_err_o, timeout, bus.wbs_stb_o} !== 6'b0000_0_1) begin errors++; $display("FAIL nowd_stall_%0d: err %b to %b stb %b want 0000 0 1", c, bus.wbm_err_o, timeout, bus.wbs_stb_o); end
            tick();
        end
        bus.wbs_ack_i = 1'b1;
        #1;
        checks++; if (bus.wbm_ack_o !== 4'b1000) begin errors++; $display("FAIL nowd_ack: got %b want 1000", bus.wbm_ack_o); end
        clear_inputs();
        tick();
    endtask
`endif

    task automatic test_reset_mid_burst();
        do_reset();
        bus.wbm_cti_i[2*3 +: 3] = CTI_INC;
        bus.wbm_cyc_i[2] = 1'b1;
        bus.wbm_stb_i[2] = 1'b1;
        tick();
        bus.wbs_ack_i = 1'b1;
        #1;
        checks++; if (bus.wbm_ack_o !== 4'b0100) begin errors++; $display("FAIL rstb_beat1: got %b want 0100", bus.wbm_ack_o); end
        tick();
        bus.wbs_ack_i = 1'b0;
        rst = 1'b1;
        tick();
        bus.wbs_ack_i = 1'b1;
        #1;
        checks++; if (bus.wbs_cyc_o !== 1'b0) begin errors++; $display("FAIL rstb_cyc: got %b want 0", bus.wbs_cyc_o); end
        checks++; if (bus.wbm_ack_o !== 4'b0000) begin errors++; $display("FAIL rstb_ack: got %b want 0000", bus.wbm_ack_o); end
        clear_inputs();
        bus.wbm_cyc_i = 4'b1001;
        bus.wbm_stb_i = 4'b1001;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.wbs_cyc_o !== 1'b0) begin errors++; $display("FAIL rstb_idle: got %b want 0", bus.wbs_cyc_o); end
        tick();
        #1;
        checks++; if (owner !== 2'd0 || bus.wbs_cyc_o !== 1'b1) begin errors++; $display("FAIL rstb_priority: owner %0d cyc %b want 0 1", owner, bus.wbs_cyc_o); end
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_master();
        test_fairness();
        test_burst_lock();
`ifdef WB_ARB_TIMEOUT_EN
        test_watchdog();
        test_ack_at_limit();
`else
        test_no_watchdog();
`endif
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t", $time);
        $fatal(1);
    end

endmodule
